// File: rtl/sram_arb2.sv
// sram_arb2: shares one sram-like bus between instruction fetch and data access.
// One outstanding downstream transaction; a starvation counter forces fetch progress.
module sram_arb2 #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          i_clk_sys,
  input  logic          i_rst_b,
  // instruction port
  input  logic          i_inst_req,
  input  logic [AW-1:0] i_inst_addr,
  output logic          o_inst_addr_ok,
  output logic          o_inst_data_ok,
  output logic [DW-1:0] o_inst_rdata,
  // data port
  input  logic          i_data_req,
  input  logic          i_data_wr,
  input  logic [1:0]    i_data_size,
  input  logic [3:0]    i_data_wstrb,
  input  logic [AW-1:0] i_data_addr,
  input  logic [DW-1:0] i_data_wdata,
  output logic          o_data_addr_ok,
  output logic          o_data_data_ok,
  output logic [DW-1:0] o_data_rdata,
  // downstream bus
  output logic          o_bus_req,
  output logic          o_bus_wr,
  output logic [1:0]    o_bus_size,
  output logic [3:0]    o_bus_wstrb,
  output logic [AW-1:0] o_bus_addr,
  output logic [DW-1:0] o_bus_wdata,
  input  logic          i_bus_addr_ok,
  input  logic          i_bus_data_ok,
  input  logic [DW-1:0] i_bus_rdata,
  // status
  output logic          o_busy
);

  // state | meaning
  // IDLE  | no transaction in flight; arbitrate and latch the winner
  // REQ   | bus_req driven from latched fields, waiting for bus_addr_ok
  // WAIT  | address accepted, waiting for bus_data_ok
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic       OWN_DATA      = 1'b0;
  localparam logic       OWN_INST      = 1'b1;
  localparam logic [2:0] LP_STARVE_MAX = 3'(STARVE_MAX);

  state_t          r_state;
  logic            r_owner;
  logic [2:0]      r_starve_cnt;
  logic            r_bus_req;
  logic            r_busy;
  logic            r_wr;
  logic [1:0]      r_size;
  logic [3:0]      r_wstrb;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;

  logic            w_any_req;
  logic            w_grant_inst;
  logic [2:0]      w_starve_inc;
  logic            w_in_req;
  logic            w_in_wait;

  assign w_any_req    = i_inst_req || i_data_req;
  // inst wins when forced by starvation, or when it is the only requester
  assign w_grant_inst = i_inst_req && ((r_starve_cnt == LP_STARVE_MAX) || !i_data_req);
  assign w_starve_inc = (r_starve_cnt == 3'd7) ? 3'd7 : r_starve_cnt + 3'd1;

  always_ff @(posedge i_clk_sys or negedge i_rst_b) begin
    if (!i_rst_b) begin
      r_state      <= IDLE;
      r_owner      <= OWN_DATA;
      r_starve_cnt <= 3'd0;
      r_bus_req    <= 1'b0;
      r_busy       <= 1'b0;
      r_wr         <= 1'b0;
      r_size       <= 2'd0;
      r_wstrb      <= 4'd0;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_state   <= REQ;
            r_bus_req <= 1'b1;
            r_busy    <= 1'b1;
            if (w_grant_inst) begin
              r_owner      <= OWN_INST;
              r_addr       <= i_inst_addr;
              r_wr         <= 1'b0;
              r_size       <= 2'd2;
              r_wstrb      <= 4'd0;
              r_wdata      <= '0;
              r_starve_cnt <= 3'd0;
            end else begin
              r_owner      <= OWN_DATA;
              r_addr       <= i_data_addr;
              r_wr         <= i_data_wr;
              r_size       <= i_data_size;
              r_wstrb      <= i_data_wstrb;
              r_wdata      <= i_data_wdata;
              r_starve_cnt <= i_inst_req ? w_starve_inc : 3'd0;
            end
          end
        end
        REQ: begin
          if (i_bus_addr_ok) begin
            r_state   <= WAIT;
            r_bus_req <= 1'b0;
          end
        end
        WAIT: begin
          if (i_bus_data_ok) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_bus_req <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign w_in_req  = (r_state == REQ);
  assign w_in_wait = (r_state == WAIT);

  // handshakes are steered combinationally so the owner sees them in the bus cycle
  assign o_inst_addr_ok = w_in_req  && i_bus_addr_ok && (r_owner == OWN_INST);
  assign o_data_addr_ok = w_in_req  && i_bus_addr_ok && (r_owner == OWN_DATA);
  assign o_inst_data_ok = w_in_wait && i_bus_data_ok && (r_owner == OWN_INST);
  assign o_data_data_ok = w_in_wait && i_bus_data_ok && (r_owner == OWN_DATA);
  assign o_inst_rdata   = i_bus_rdata;
  assign o_data_rdata   = i_bus_rdata;

  assign o_bus_req   = r_bus_req;
  assign o_bus_wr    = r_wr;
  assign o_bus_size  = r_size;
  assign o_bus_wstrb = r_wstrb;
  assign o_bus_addr  = r_addr;
  assign o_bus_wdata = r_wdata;
  assign o_busy      = r_busy;

endmodule
